spi_tx_arbiter: RTL and testbench
=================================

// Module: spi_tx_arbiter
// PURPOSE
//  Two-requester SPI byte transmitter: arbitrates req0/req1 round-robin, latches the winner's
//  byte and serializes it MSB-first on spi_mosi/spi_sclk, framed by active-low spi_cs_n
//  (SPI mode 0). Sits between on-chip byte producers and the IOB pins. Replaces free-running
//  rotate-register output with a proper framed, shared transmitter.
// PARAMETERS
//  CLK_DIV  4  clk cycles per SCLK half-period; legal range 1..255; SCLK = clk/(2*CLK_DIV)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous active-low reset
//  req        in   2  req[i]=1: requester i has a byte on data_i; hold until gnt[i]
//  data0      in   8  byte from requester 0, stable while req[0]=1
//  data1      in   8  byte from requester 1, stable while req[1]=1
//  gnt        out  2  one-cycle pulse; data_i captured at the posedge raising gnt[i]
//  src        out  1  index of current/last granted requester
//  busy       out  1  1 in every state except IDLE
//  done       out  1  one-cycle pulse on the cycle spi_cs_n returns high
//  spi_sclk   out  1  serial clock, idle low
//  spi_mosi   out  1  serial data, MSB first; 0 whenever spi_cs_n=1
//  spi_cs_n   out  1  chip select, active low for whole byte frame
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, src=0, busy=0, done=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1,
//   state=IDLE, RR pointer favours req0, divider and bit counters=0. All outputs registered.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  IDLE: at posedge with req!=0: pick winner (only one set -> it; both set -> requester not
//   granted last; first after reset -> 0). Same edge: gnt[w]=1, src=w, shreg<=data_w,
//   spi_cs_n=0, spi_mosi=data_w[7], busy=1, state=SETUP. gnt drops next cycle.
//  SETUP: CLK_DIV cycles, sclk low (MOSI setup time).
//  SHIFT: 8 bit periods; each = CLK_DIV cycles sclk high then CLK_DIV cycles sclk low.
//   spi_mosi changes only on high->low transition, to next lower bit; after bit 0 it holds.
//   Exactly 8 rising edges per frame; slave samples on rising edge.
//  HOLD: CLK_DIV cycles, sclk low, cs_n low. At exit: spi_cs_n=1, spi_mosi=0, done=1 (1 cycle).
//  GAP: CLK_DIV cycles with cs_n high; req ignored. Then IDLE; busy=0 only in IDLE.
//  Frame: cs_n low for (1+16+1)*CLK_DIV = 18*CLK_DIV cycles (72 @ CLK_DIV=4); minimum
//   gnt-to-gnt spacing 19*CLK_DIV+1 cycles.
//  req is sampled only in IDLE; a req raised and dropped while busy is never granted.
//  RR pointer updates on each grant only; req toggling outside IDLE has no effect.
//  Divider: 8-bit down-counter reloaded with CLK_DIV-1 on each phase boundary; bit counter 3 bit.
//  Reset mid-frame: cs_n forced high and sclk low asynchronously; partial byte discarded, no done.
// TESTING
//  1 CLK_DIV=4, req0 with 0xA5 -> gnt[0] 1 cycle after req, cs_n low 72 cycles, MOSI at 8 sclk
//    rises = 1,0,1,0,0,1,0,1, one done pulse, busy low 4 cycles after cs_n rises.
//  2 req0=0x3C and req1=0xC3 both held from reset -> frame 0x3C (src=0) then 0xC3 (src=1),
//    cs_n high >=4 cycles between frames, two gnt pulses total.
//  3 both reqs held continuously, 6 frames -> src sequence 0,1,0,1,0,1.
//  4 rst_n low after 3rd sclk rise of 0xFF frame -> cs_n=1, sclk=0, mosi=0 same cycle, no done;
//    after release req1=0x81 -> full clean frame, src=1.
//  5 req1 pulsed 2 cycles during busy frame -> no gnt[1], no extra frame.
//  6 CLK_DIV=1, req0=0x55 -> sclk period 2 clk cycles, cs_n low 18 cycles, bits 01010101.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_arbiter
// Brief    : Two-requester round-robin arbiter feeding a framed SPI mode-0
//            byte transmitter (MSB first, active-low chip select).
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic       src,
    output logic       busy,
    output logic       done,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    localparam logic [7:0] c_DIV_RELOAD = 8'(CLK_DIV - 1);

    logic [2:0] r_state, w_state_nxt;
    logic [7:0] r_div, w_div_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic       r_phase_hi, w_phase_hi_nxt;
    logic [7:0] r_shreg, w_shreg_nxt;
    logic       r_last, w_last_nxt;
    logic [1:0] r_gnt, w_gnt_nxt;
    logic       r_src, w_src_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_sclk, w_sclk_nxt;
    logic       r_mosi, w_mosi_nxt;
    logic       r_cs_n, w_cs_n_nxt;

    logic       w_div_zero;
    logic       w_win;
    logic [7:0] w_win_data;

    assign w_div_zero = (r_div == 8'd0);

    // r_last holds the previous winner; reset value 1 makes requester 0 win the first tie.
    always_comb begin
        w_win = 1'b0;
        if (req == 2'b10)
            w_win = 1'b1;
        else if (req == 2'b11)
            w_win = ~r_last;
    end

    assign w_win_data = w_win ? data1 : data0;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_div      <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_phase_hi <= 1'b0;
            r_shreg    <= 8'd0;
            r_last     <= 1'b1;
            r_gnt      <= 2'b00;
            r_src      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_phase_hi <= w_phase_hi_nxt;
            r_shreg    <= w_shreg_nxt;
            r_last     <= w_last_nxt;
            r_gnt      <= w_gnt_nxt;
            r_src      <= w_src_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_cs_n     <= w_cs_n_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (req != 2'b00) w_state_nxt = c_SETUP;
            c_SETUP: if (w_div_zero) w_state_nxt = c_SHIFT;
            c_SHIFT: if (w_div_zero && !r_phase_hi && (r_bit_cnt == 3'd7))
                         w_state_nxt = c_HOLD;
            c_HOLD:  if (w_div_zero) w_state_nxt = c_GAP;
            c_GAP:   if (w_div_zero) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_div_nxt      = r_div;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_phase_hi_nxt = r_phase_hi;
        w_shreg_nxt    = r_shreg;
        w_last_nxt     = r_last;
        w_gnt_nxt      = 2'b00;
        w_src_nxt      = r_src;
        w_done_nxt     = 1'b0;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_cs_n_nxt     = r_cs_n;
        w_busy_nxt     = (w_state_nxt != c_IDLE);

        case (r_state)
            c_IDLE: begin
                if (req != 2'b00) begin
                    w_gnt_nxt[w_win] = 1'b1;
                    w_src_nxt        = w_win;
                    w_last_nxt       = w_win;
                    w_shreg_nxt      = w_win_data;
                    w_mosi_nxt       = w_win_data[7];
                    w_cs_n_nxt       = 1'b0;
                    w_div_nxt        = c_DIV_RELOAD;
                    w_bit_cnt_nxt    = 3'd0;
                    w_phase_hi_nxt   = 1'b0;
                end
            end
            c_SETUP: begin
                if (w_div_zero) begin
                    w_div_nxt      = c_DIV_RELOAD;
                    w_sclk_nxt     = 1'b1;
                    w_phase_hi_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div - 8'd1;
                end
            end
            c_SHIFT: begin
                if (!w_div_zero) begin
                    w_div_nxt = r_div - 8'd1;
                end else begin
                    w_div_nxt = c_DIV_RELOAD;
                    if (r_phase_hi) begin
                        // Falling edge: advance to the next lower bit, except after bit 0.
                        w_sclk_nxt     = 1'b0;
                        w_phase_hi_nxt = 1'b0;
                        if (r_bit_cnt != 3'd7) begin
                            w_mosi_nxt  = r_shreg[6];
                            w_shreg_nxt = {r_shreg[6:0], 1'b0};
                        end
                    end else if (r_bit_cnt != 3'd7) begin
                        w_sclk_nxt     = 1'b1;
                        w_phase_hi_nxt = 1'b1;
                        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                    end
                end
            end
            c_HOLD: begin
                if (w_div_zero) begin
                    w_div_nxt  = c_DIV_RELOAD;
                    w_cs_n_nxt = 1'b1;
                    w_mosi_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div - 8'd1;
                end
            end
            c_GAP: begin
                if (!w_div_zero)
                    w_div_nxt = r_div - 8'd1;
            end
            default: begin
                w_div_nxt = 8'd0;
            end
        endcase
    end

    assign gnt      = r_gnt;
    assign src      = r_src;
    assign busy     = r_busy;
    assign done     = r_done;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_arbiter
// Brief    : Directed self-checking bench for spi_tx_arbiter at CLK_DIV=4 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_v = 2'b00;
    logic [7:0] data0_v = 8'h00;
    logic [7:0] data1_v = 8'h00;
    int         sel = 0;

    wire [1:0] w_req_a = (sel == 0) ? req_v : 2'b00;
    wire [1:0] w_req_b = (sel == 1) ? req_v : 2'b00;

    logic [1:0] gnt_a, gnt_b;
    logic       src_a, src_b, busy_a, busy_b, done_a, done_b;
    logic       sclk_a, sclk_b, mosi_a, mosi_b, cs_n_a, cs_n_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_tx_arbiter #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(w_req_a), .data0(data0_v), .data1(data1_v),
        .gnt(gnt_a), .src(src_a), .busy(busy_a), .done(done_a),
        .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_cs_n(cs_n_a)
    );

    spi_tx_arbiter #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(w_req_b), .data0(data0_v), .data1(data1_v),
        .gnt(gnt_b), .src(src_b), .busy(busy_b), .done(done_b),
        .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_cs_n(cs_n_b)
    );

    wire [1:0] m_gnt  = (sel == 1) ? gnt_b  : gnt_a;
    wire       m_src  = (sel == 1) ? src_b  : src_a;
    wire       m_busy = (sel == 1) ? busy_b : busy_a;
    wire       m_done = (sel == 1) ? done_b : done_a;
    wire       m_sclk = (sel == 1) ? sclk_b : sclk_a;
    wire       m_mosi = (sel == 1) ? mosi_b : mosi_a;
    wire       m_cs_n = (sel == 1) ? cs_n_b : cs_n_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Observes one frame from "now"; drop=1 releases each request once its grant is seen.
    task automatic capture(input int drop, input int stop_rises, input int pulse_at,
                           output logic [7:0] b, output int first_low, output int cs_low,
                           output int rises, output int dones, output int g0, output int g1,
                           output logic src_at, output int rise_span, output bit to);
        int t;
        int rise_first;
        logic prev_sclk;
        bit seen_low;
        bit fin;
        b = 8'h00; first_low = -1; cs_low = 0; rises = 0; dones = 0; g0 = 0; g1 = 0;
        src_at = 1'b0; rise_span = 0; rise_first = 0; to = 1'b0;
        t = 0; prev_sclk = m_sclk; seen_low = 1'b0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            t++;
            if (pulse_at > 0) begin
                if (t == pulse_at) req_v[1] = 1'b1;
                if (t == pulse_at + 2) req_v[1] = 1'b0;
            end
            if (m_gnt[0]) g0++;
            if (m_gnt[1]) g1++;
            if (drop != 0) begin
                if (m_gnt[0]) req_v[0] = 1'b0;
                if (m_gnt[1]) req_v[1] = 1'b0;
            end
            if (m_done) dones++;
            if (m_cs_n == 1'b0) begin
                if (!seen_low) begin
                    first_low = t;
                    src_at = m_src;
                end
                seen_low = 1'b1;
                cs_low++;
                if (m_sclk && !prev_sclk) begin
                    b = {b[6:0], m_mosi};
                    rises++;
                    if (rises == 1) rise_first = t;
                    rise_span = t - rise_first;
                    if (stop_rises > 0 && rises == stop_rises) fin = 1'b1;
                end
            end else if (seen_low) begin
                fin = 1'b1;
            end
            prev_sclk = m_sclk;
            if (t > 2000) begin
                to = 1'b1;
                fin = 1'b1;
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] b;
        int first_low, cs_low, rises, dones, g0, g1, span, n, gn;
        logic src_at;
        logic [5:0] src_seq;
        bit to;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", m_gnt, 2'b00);
        check("rst_src", m_src, 1'b0);
        check("rst_busy", m_busy, 1'b0);
        check("rst_done", m_done, 1'b0);
        check("rst_sclk", m_sclk, 1'b0);
        check("rst_mosi", m_mosi, 1'b0);
        check("rst_cs_n", m_cs_n, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame 0xA5 from requester 0
        data0_v = 8'hA5;
        req_v = 2'b01;
        capture(1, 0, 0, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
        check("t1_timeout", to, 1'b0);
        check("t1_first_low", first_low, 1);
        check("t1_byte", b, 8'hA5);
        check("t1_cs_low", cs_low, 72);
        check("t1_rises", rises, 8);
        check("t1_done", dones, 1);
        check("t1_gnt0", g0, 1);
        check("t1_gnt1", g1, 0);
        check("t1_src", src_at, 1'b0);
        check("t1_mosi_idle", m_mosi, 1'b0);
        n = 0;
        while (m_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t1_busy_drop", n, 4);

        // 2: both requests held from reset
        rst_n = 1'b0;
        data0_v = 8'h3C;
        data1_v = 8'hC3;
        req_v = 2'b11;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        capture(1, 0, 0, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
        check("t2a_timeout", to, 1'b0);
        check("t2a_byte", b, 8'h3C);
        check("t2a_src", src_at, 1'b0);
        check("t2a_gnt0", g0, 1);
        check("t2a_gnt1", g1, 0);
        capture(1, 0, 0, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
        check("t2b_timeout", to, 1'b0);
        check("t2b_gap", first_low, 5);
        check("t2b_byte", b, 8'hC3);
        check("t2b_src", src_at, 1'b1);
        check("t2b_gnt0", g0, 0);
        check("t2b_gnt1", g1, 1);
        gn = 0;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (m_gnt != 2'b00) gn++;
            if (m_cs_n == 1'b0) n++;
        end
        check("t2_no_extra_gnt", gn, 0);
        check("t2_no_extra_frame", n, 0);

        // 3: continuous contention alternates
        do_reset();
        data0_v = 8'h11;
        data1_v = 8'h22;
        req_v = 2'b11;
        src_seq = 6'b0;
        for (int k = 0; k < 6; k++) begin
            capture(0, 0, 0, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
            check("t3_timeout", to, 1'b0);
            src_seq[k] = src_at;
            check("t3_byte", b, src_at ? 8'h22 : 8'h11);
        end
        req_v = 2'b00;
        check("t3_src_seq", src_seq, 6'b101010);
        repeat (30) @(negedge clk);

        // 4: reset mid-frame, then clean frame from requester 1
        do_reset();
        data0_v = 8'hFF;
        req_v = 2'b01;
        capture(1, 3, 0, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
        check("t4_timeout", to, 1'b0);
        check("t4_pre_done", dones, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_cs_n", m_cs_n, 1'b1);
        check("t4_sclk", m_sclk, 1'b0);
        check("t4_mosi", m_mosi, 1'b0);
        check("t4_busy", m_busy, 1'b0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_done) n++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (m_done) n++;
        end
        check("t4_no_done", n, 0);
        data1_v = 8'h81;
        req_v = 2'b10;
        capture(1, 0, 0, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
        check("t4_timeout2", to, 1'b0);
        check("t4_byte", b, 8'h81);
        check("t4_src", src_at, 1'b1);
        check("t4_cs_low", cs_low, 72);
        check("t4_done", dones, 1);

        // 5: short req1 pulse during a busy frame is never granted
        repeat (10) @(negedge clk);
        data0_v = 8'h5A;
        data1_v = 8'h99;
        req_v = 2'b01;
        capture(1, 0, 20, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
        check("t5_timeout", to, 1'b0);
        check("t5_byte", b, 8'h5A);
        check("t5_gnt1", g1, 0);
        gn = 0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_gnt != 2'b00) gn++;
            if (m_cs_n == 1'b0) n++;
        end
        check("t5_no_gnt", gn, 0);
        check("t5_no_frame", n, 0);

        // 6: CLK_DIV=1 instance
        sel = 1;
        do_reset();
        data0_v = 8'h55;
        req_v = 2'b01;
        capture(1, 0, 0, b, first_low, cs_low, rises, dones, g0, g1, src_at, span, to);
        check("t6_timeout", to, 1'b0);
        check("t6_byte", b, 8'h55);
        check("t6_cs_low", cs_low, 18);
        check("t6_rises", rises, 8);
        check("t6_rise_span", span, 14);
        check("t6_done", dones, 1);
        repeat (5) @(negedge clk);
        check("t6_idle_busy", m_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
